// File: rtl/sh7604_pwr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sh7604_pwr_ctrl
//  Description : SH7604 power-down controller. Owns SBYCR/WKCR and sequences
//                RUN/SLEEP/STANDBY/SETTLE with stop, clock-gate and Hi-Z outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sh7604_pwr_ctrl #(
    parameter int          NUM_MOD    = 5,
    parameter int          NUM_WAKE   = 4,
    parameter logic [31:0] SBYCR_ADDR = 32'hFFFFFE91,
    parameter logic [15:0] SETTLE_CYC = 16'd1024
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CE_R,
    input  logic                CE_F,
    input  logic                EN,
    input  logic                RES_N,
    input  logic [31:0]         IBUS_A,
    input  logic [31:0]         IBUS_DI,
    output logic [31:0]         IBUS_DO,
    input  logic [3:0]          IBUS_BA,
    input  logic                IBUS_WE,
    input  logic                IBUS_REQ,
    output logic                IBUS_BUSY,
    output logic                IBUS_ACT,
    input  logic                SLEEP,
    input  logic                IRQ,
    input  logic                NMI,
    input  logic [NUM_WAKE-1:0] WAKE,
    input  logic                WDT_OVF,
    output logic                SLP,
    output logic                SBY,
    output logic                CLK_STOP,
    output logic                HIZ,
    output logic [NUM_MOD-1:0]  MSTP,
    output logic                WAKEUP
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SLEEP  = 2'd1,
        ST_STBY   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam logic [7:0]  c_sbycr_mask  = 8'hC0 | 8'((1 << NUM_MOD) - 1);
    localparam logic [7:0]  c_wkcr_mask   = 8'((1 << NUM_WAKE) - 1);
    localparam logic [15:0] c_settle_load = (SETTLE_CYC == 16'd0) ? 16'd0 : SETTLE_CYC - 16'd1;

    state_t              r_state;
    logic [7:0]          r_sbycr;
    logic [7:0]          r_wkcr;
    logic [15:0]         r_cnt;
    logic                r_sleep_old;
    logic [31:0]         r_reg_do;
    logic                r_slp;
    logic                r_sby;
    logic                r_clk_stop;
    logic                r_hiz;
    logic [NUM_MOD-1:0]  r_mstp;
    logic                r_wakeup;

    logic                w_hit_sby;
    logic                w_hit_wk;
    logic                w_hit;
    logic                w_tick;
    logic                w_wr;
    logic                w_be;
    logic [7:0]          w_wr_byte;
    logic [7:0]          w_rd_byte;
    logic                w_rise;
    logic                w_wake_hit;
    logic                w_sby_nxt;
    state_t              w_state_nxt;
    logic [7:0]          w_sbycr_nxt;
    logic [7:0]          w_wkcr_nxt;
    logic [15:0]         w_cnt_nxt;

    assign w_hit_sby  = (IBUS_A == SBYCR_ADDR);
    assign w_hit_wk   = (IBUS_A == SBYCR_ADDR + 32'd1);
    assign w_hit      = w_hit_sby | w_hit_wk;
    assign w_tick     = EN & CE_R;
    assign w_wr       = w_tick & IBUS_REQ & IBUS_WE & w_be;
    assign w_rd_byte  = w_hit_sby ? r_sbycr : r_wkcr;
    assign w_rise     = SLEEP & ~r_sleep_old;
    assign w_wake_hit = |(WAKE & r_wkcr[NUM_WAKE-1:0]);
    assign w_sby_nxt  = (w_state_nxt == ST_STBY) || (w_state_nxt == ST_SETTLE);

    // Big-endian lanes: address offset 0 is the most significant byte.
    always_comb begin
        w_wr_byte = IBUS_DI[31:24];
        w_be      = IBUS_BA[3];
        case (IBUS_A[1:0])
            2'd0: begin w_wr_byte = IBUS_DI[31:24]; w_be = IBUS_BA[3]; end
            2'd1: begin w_wr_byte = IBUS_DI[23:16]; w_be = IBUS_BA[2]; end
            2'd2: begin w_wr_byte = IBUS_DI[15:8];  w_be = IBUS_BA[1]; end
            default: begin w_wr_byte = IBUS_DI[7:0]; w_be = IBUS_BA[0]; end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sbycr_nxt = r_sbycr;
        w_wkcr_nxt  = r_wkcr;
        w_cnt_nxt   = r_cnt;
        if (w_wr && w_hit_sby)
            w_sbycr_nxt = w_wr_byte & c_sbycr_mask;
        if (w_wr && w_hit_wk)
            w_wkcr_nxt = w_wr_byte & c_wkcr_mask;
        case (r_state)
            ST_RUN: begin
                if (w_rise)
                    w_state_nxt = r_sbycr[7] ? ST_STBY : ST_SLEEP;
            end
            ST_SLEEP: begin
                if (IRQ || NMI || w_wake_hit || WDT_OVF)
                    w_state_nxt = ST_RUN;
            end
            ST_STBY: begin
                if (NMI || w_wake_hit) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = c_settle_load;
                end
            end
            default: begin
                if (r_cnt == 16'd0 || WDT_OVF) begin
                    w_state_nxt    = ST_RUN;
                    w_cnt_nxt      = 16'd0;
                    w_sbycr_nxt[7] = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_sbycr     <= 8'h00;
            r_wkcr      <= 8'h00;
            r_cnt       <= 16'd0;
            r_sleep_old <= 1'b0;
            r_reg_do    <= 32'd0;
            r_slp       <= 1'b0;
            r_sby       <= 1'b0;
            r_clk_stop  <= 1'b0;
            r_hiz       <= 1'b0;
            r_mstp      <= '0;
            r_wakeup    <= 1'b0;
        end else begin
            if (EN && CE_F && IBUS_REQ && !IBUS_WE && w_hit)
                r_reg_do <= {4{w_rd_byte}};
            if (w_tick) begin
                // The CPU reset pin re-initialises everything except the read latch.
                if (!RES_N) begin
                    r_state     <= ST_RUN;
                    r_sbycr     <= 8'h00;
                    r_wkcr      <= 8'h00;
                    r_cnt       <= 16'd0;
                    r_sleep_old <= 1'b0;
                    r_slp       <= 1'b0;
                    r_sby       <= 1'b0;
                    r_clk_stop  <= 1'b0;
                    r_hiz       <= 1'b0;
                    r_mstp      <= '0;
                    r_wakeup    <= 1'b0;
                end else begin
                    r_state     <= w_state_nxt;
                    r_sbycr     <= w_sbycr_nxt;
                    r_wkcr      <= w_wkcr_nxt;
                    r_cnt       <= w_cnt_nxt;
                    r_sleep_old <= SLEEP;
                    r_slp       <= (w_state_nxt == ST_SLEEP);
                    r_sby       <= w_sby_nxt;
                    r_clk_stop  <= (w_state_nxt != ST_RUN);
                    r_hiz       <= (w_state_nxt == ST_STBY) && w_sbycr_nxt[6];
                    r_mstp      <= w_sby_nxt ? '1 : w_sbycr_nxt[NUM_MOD-1:0];
                    r_wakeup    <= (w_state_nxt == ST_RUN) &&
                                   (r_state == ST_SLEEP || r_state == ST_SETTLE);
                end
            end
        end
    end

    assign IBUS_DO   = w_hit ? r_reg_do : 32'd0;
    assign IBUS_BUSY = 1'b0;
    assign IBUS_ACT  = w_hit;
    assign SLP       = r_slp;
    assign SBY       = r_sby;
    assign CLK_STOP  = r_clk_stop;
    assign HIZ       = r_hiz;
    assign MSTP      = r_mstp;
    assign WAKEUP    = r_wakeup;

endmodule
`default_nettype wire

// File: tb/tb_sh7604_pwr_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sh7604_pwr_ctrl
//  Description : Directed scoreboard bench for sh7604_pwr_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sh7604_pwr_ctrl;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, EN, RES_N;
    logic [31:0] IBUS_A, IBUS_DI, IBUS_DO;
    logic [3:0]  IBUS_BA;
    logic        IBUS_WE, IBUS_REQ, IBUS_BUSY, IBUS_ACT;
    logic        SLEEP, IRQ, NMI, WDT_OVF;
    logic [3:0]  WAKE;
    logic        SLP, SBY, CLK_STOP, HIZ, WAKEUP;
    logic [4:0]  MSTP;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    sh7604_pwr_ctrl #(
        .NUM_MOD    (5),
        .NUM_WAKE   (4),
        .SBYCR_ADDR (32'hFFFFFE91),
        .SETTLE_CYC (16'd1024)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE_R      (CE_R),
        .CE_F      (CE_F),
        .EN        (EN),
        .RES_N     (RES_N),
        .IBUS_A    (IBUS_A),
        .IBUS_DI   (IBUS_DI),
        .IBUS_DO   (IBUS_DO),
        .IBUS_BA   (IBUS_BA),
        .IBUS_WE   (IBUS_WE),
        .IBUS_REQ  (IBUS_REQ),
        .IBUS_BUSY (IBUS_BUSY),
        .IBUS_ACT  (IBUS_ACT),
        .SLEEP     (SLEEP),
        .IRQ       (IRQ),
        .NMI       (NMI),
        .WAKE      (WAKE),
        .WDT_OVF   (WDT_OVF),
        .SLP       (SLP),
        .SBY       (SBY),
        .CLK_STOP  (CLK_STOP),
        .HIZ       (HIZ),
        .MSTP      (MSTP),
        .WAKEUP    (WAKEUP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] st(input logic slp, input logic sby, input logic cs,
                                       input logic hiz, input logic wk, input logic [4:0] mstp);
        return {22'd0, slp, sby, cs, hiz, wk, mstp};
    endfunction

    function automatic logic [31:0] obs_stat();
        return {22'd0, SLP, SBY, CLK_STOP, HIZ, WAKEUP, MSTP};
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    // One CE_R clock followed by one CE_F clock; returns at a falling edge.
    task automatic tick();
        @(negedge CLK); CE_R = 1'b1; CE_F = 1'b0;
        @(negedge CLK); CE_R = 1'b0; CE_F = 1'b1;
        @(negedge CLK); CE_F = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
        IBUS_A = a; IBUS_DI = d; IBUS_BA = ba; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
        tick();
        IBUS_WE = 1'b0; IBUS_REQ = 1'b0; IBUS_BA = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a);
        IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        tick();
        IBUS_REQ = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1; CE_R = 1'b0; CE_F = 1'b0; EN = 1'b1; RES_N = 1'b1;
        IBUS_A = 32'd0; IBUS_DI = 32'd0; IBUS_BA = 4'd0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        SLEEP = 1'b0; IRQ = 1'b0; NMI = 1'b0; WAKE = 4'd0; WDT_OVF = 1'b0;
        tick(); tick();
        push("reset_outputs", st(0, 0, 0, 0, 0, 5'b00000)); check(obs_stat());
        push("reset_do", 32'd0);                             check(IBUS_DO);
        push("busy", 32'd0);                                 check({31'd0, IBUS_BUSY});
        RST = 1'b0;

        bus_write(32'hFFFFFE91, 32'h00C30000, 4'b0100);
        push("sbycr_c3_mstp", st(0, 0, 0, 0, 0, 5'b00011)); check(obs_stat());
        bus_read(32'hFFFFFE91);
        push("sbycr_c3_read", 32'hC3C3C3C3);                check(IBUS_DO);
        push("act_hit", 32'd1);                             check({31'd0, IBUS_ACT});
        bus_write(32'hFFFFFE91, 32'h00FF0000, 4'b0100);
        bus_read(32'hFFFFFE91);
        push("sbycr_mask", 32'hDFDFDFDF);                   check(IBUS_DO);
        bus_write(32'hFFFFFE92, 32'h0000FF00, 4'b0010);
        bus_read(32'hFFFFFE92);
        push("wkcr_mask", 32'h0F0F0F0F);                    check(IBUS_DO);
        IBUS_A = 32'hFFFFFE94;
        #1;
        push("miss_do", 32'd0);                             check(IBUS_DO);
        bus_write(32'hFFFFFE92, 32'h00000200, 4'b0010);
        bus_write(32'hFFFFFE91, 32'h00030000, 4'b0100);

        SLEEP = 1'b1; tick();
        push("sleep_enter", st(1, 0, 1, 0, 0, 5'b00011));   check(obs_stat());
        EN = 1'b0; IRQ = 1'b1; tick();
        push("en_hold", st(1, 0, 1, 0, 0, 5'b00011));       check(obs_stat());
        EN = 1'b1; tick();
        push("irq_wake", st(0, 0, 0, 0, 1, 5'b00011));      check(obs_stat());
        IRQ = 1'b0; tick();
        push("wakeup_pulse", st(0, 0, 0, 0, 0, 5'b00011));  check(obs_stat());
        SLEEP = 1'b0; tick();
        SLEEP = 1'b1; NMI = 1'b1; tick();
        push("sleep_nmi_same", st(1, 0, 1, 0, 0, 5'b00011)); check(obs_stat());
        tick();
        push("nmi_next_wake", st(0, 0, 0, 0, 1, 5'b00011)); check(obs_stat());
        NMI = 1'b0; SLEEP = 1'b0; tick();

        bus_write(32'hFFFFFE91, 32'h00C00000, 4'b0100);
        SLEEP = 1'b1; tick();
        push("stby_enter", st(0, 1, 1, 1, 0, 5'b11111));    check(obs_stat());
        SLEEP = 1'b0; IRQ = 1'b1; tick();
        push("stby_irq_ignored", st(0, 1, 1, 1, 0, 5'b11111)); check(obs_stat());
        IRQ = 1'b0; NMI = 1'b1; tick();
        push("settle_enter", st(0, 1, 1, 0, 0, 5'b11111));  check(obs_stat());
        NMI = 1'b0;
        n = 0;
        while (SBY === 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        push("settle_len", 32'd1024);                       check(32'(n));
        push("settle_exit", st(0, 0, 0, 0, 1, 5'b00000));   check(obs_stat());
        bus_read(32'hFFFFFE91);
        push("sby_cleared", 32'h40404040);                  check(IBUS_DO);

        bus_write(32'hFFFFFE91, 32'h00C00000, 4'b0100);
        SLEEP = 1'b1; tick(); SLEEP = 1'b0;
        WAKE = 4'b0001; tick();
        push("wake_masked", st(0, 1, 1, 1, 0, 5'b11111));   check(obs_stat());
        WAKE = 4'b0010; tick();
        push("wake_enabled", st(0, 1, 1, 0, 0, 5'b11111));  check(obs_stat());
        WAKE = 4'b0000;
        repeat (523) tick();
        push("settle_500", st(0, 1, 1, 0, 0, 5'b11111));    check(obs_stat());
        WDT_OVF = 1'b1; tick();
        push("wdt_exit", st(0, 0, 0, 0, 1, 5'b00000));      check(obs_stat());
        WDT_OVF = 1'b0;

        bus_write(32'hFFFFFE91, 32'h00C00000, 4'b0100);
        SLEEP = 1'b1; tick(); SLEEP = 1'b0;
        NMI = 1'b1; tick(); NMI = 1'b0;
        repeat (10) tick();
        bus_read(32'hFFFFFE91);
        push("settle_read", 32'hC0C0C0C0);                  check(IBUS_DO);
        RES_N = 1'b0; tick();
        push("resn_outputs", st(0, 0, 0, 0, 0, 5'b00000));  check(obs_stat());
        push("resn_keeps_do", 32'hC0C0C0C0);                check(IBUS_DO);
        RES_N = 1'b1;
        bus_read(32'hFFFFFE92);
        push("resn_wkcr", 32'd0);                           check(IBUS_DO);
        bus_read(32'hFFFFFE91);
        push("resn_sbycr", 32'd0);                          check(IBUS_DO);

        bus_write(32'hFFFFFE91, 32'h00030000, 4'b0100);
        bus_read(32'hFFFFFE91);
        push("pre_rst_read", 32'h03030303);                 check(IBUS_DO);
        RST = 1'b1; tick();
        push("rst_outputs", st(0, 0, 0, 0, 0, 5'b00000));   check(obs_stat());
        push("rst_do", 32'd0);                              check(IBUS_DO);
        RST = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sh7604_pwr_ctrl.md
Name: sh7604_pwr_ctrl

Overview:
- Parametrised power-down controller for the SH7604 core; successor to the single-register standby latch.
- Owns SBYCR (standby/module-stop) and WKCR (wake-enable) on the internal bus.
- Sequences RUN/SLEEP/STANDBY/SETTLE states from SLEEP-instruction, interrupt, NMI and watchdog events.
- Drives per-module stop, clock-stop and pin Hi-Z controls.

Parameters:
- NUM_MOD, 5: module-stop bit count (1..5); SBYCR[NUM_MOD-1:0] = MSTP.
- NUM_WAKE, 4: external wake source count (1..8); WKCR[NUM_WAKE-1:0] = wake enables.
- SBYCR_ADDR, 32'hFFFFFE91: SBYCR byte address; WKCR sits at SBYCR_ADDR+1.
- SETTLE_CYC, 16'd1024: oscillator settling length, counted in CE_R cycles.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- CE_R  in  1  rising-phase clock enable.
- CE_F  in  1  falling-phase clock enable.
- EN  in  1  block enable; gates state/register updates.
- RES_N  in  1  CPU reset pin; low forces RUN and register init.
- IBUS_A  in  32  bus address.
- IBUS_DI  in  32  write data, big-endian byte lanes.
- IBUS_DO  out  32  read data.
- IBUS_BA  in  4  byte enables.
- IBUS_WE  in  1  write strobe.
- IBUS_REQ  in  1  access request.
- IBUS_BUSY  out  1  always 0.
- IBUS_ACT  out  1  address hits SBYCR or WKCR.
- SLEEP  in  1  SLEEP instruction executing (level).
- IRQ  in  1  any pending accepted interrupt.
- NMI  in  1  NMI request.
- WAKE  in  NUM_WAKE  external wake requests.
- WDT_OVF  in  1  watchdog overflow pulse.
- SLP  out  1  sleep state.
- SBY  out  1  standby or settle state.
- CLK_STOP  out  1  CPU clock gated.
- HIZ  out  1  pins Hi-Z in standby.
- MSTP  out  NUM_MOD  module stop.
- WAKEUP  out  1  one-cycle pulse on return to RUN.

Behaviour:
- Reset:
  - All outputs 0; SBYCR=8'h00; WKCR=8'h00; state RUN; counter 0; REG_DO=0.
  - RES_N low (sampled when EN && CE_R) has the same effect except REG_DO.
- Registers, updated when EN && CE_R && IBUS_REQ && IBUS_WE:
  - Byte lane = IBUS_A[1:0], big-endian: lane0=DI[31:24].
  - SBYCR bits: 7=SBY, 6=HIZ, [NUM_MOD-1:0]=MSTP; other bits write 0, read 0.
  - WKCR: [NUM_WAKE-1:0] writable; others 0.
  - Writes are accepted in any state.
- Read:
  - On CE_F with IBUS_REQ && !IBUS_WE && hit, REG_DO = selected byte replicated ×4.
  - IBUS_DO = REG_DO while hit, else 0.
- SLEEP edge: SLEEP_OLD is registered on EN && CE_R; rise = SLEEP && !SLEEP_OLD.
- State machine (advances only on EN && CE_R):
  - RUN:
    - rise && SBYCR.SBY -> STBY.
    - rise && !SBY -> SLEEP.
  - SLEEP:
    - IRQ || NMI || |(WAKE & WKCR) -> RUN.
    - WDT_OVF -> RUN.
  - STBY:
    - NMI || |(WAKE & WKCR) -> SETTLE; counter loads SETTLE_CYC-1.
    - IRQ is ignored.
  - SETTLE:
    - Counter decrements each CE_R.
    - Counter==0 or WDT_OVF -> RUN; SBYCR.SBY is cleared on exit.
  - Simultaneous events:
    - RES_N beats everything.
    - In RUN, a SLEEP rise in the same cycle as NMI still enters SLEEP/STBY; NMI wakes next cycle.
    - SETTLE_CYC=0 behaves as 1.
- Outputs (registered):
  - SLP = (state==SLEEP).
  - SBY = (state==STBY || state==SETTLE).
  - CLK_STOP = (state!=RUN).
  - HIZ = (state==STBY) && SBYCR.HIZ.
  - MSTP = SBYCR.MSTP, forced all-ones while SBY.
  - WAKEUP = 1 for exactly one CE_R cycle after entering RUN from SLEEP or SETTLE.
- Latency: state outputs update on the same CE_R edge as the transition; all outputs hold when !EN.

Test Plan:
- Write byte 8'hC3 at FFFFFE91 via DI[23:16], BA=4'b0100 -> SBYCR reads 8'hC3 with NUM_MOD=5; IBUS_DO=32'hC3C3C3C3; MSTP=5'b00011.
- SBYCR.SBY=0, SLEEP rises -> SLP=1, CLK_STOP=1; IRQ pulse -> next CE_R SLP=0, WAKEUP one cycle.
- SBYCR=8'hC0, SLEEP rises -> SBY=1, HIZ=1, MSTP=5'h1F; IRQ ignored; NMI -> HIZ=0, exactly SETTLE_CYC CE_R cycles to RUN; SBYCR.SBY reads 0.
- WKCR=4'b0010: WAKE=4'b0001 in STBY -> no exit; WAKE=4'b0010 -> SETTLE.
- WDT_OVF in SETTLE at count 500 -> RUN next CE_R.
- RES_N low mid-SETTLE -> RUN, SBYCR=0, all outputs 0; RST=1 -> same plus IBUS_DO=0.
